mem_port_arbiter: RTL

//  Shares the single axi_ctl memory port between icache (read-only refills) and dcache
//  (dirty write-back + refill). Grants one master at a time; the grant is held until that

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
//----------------------------------------------------------------------------
// Module  : mem_port_arbiter_if
// Brief   : Cache-side and axi_ctl-side bus bundle for mem_port_arbiter.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 9
);
    // icache side
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [IDX_W-1:0]  i_fifo_idx;
    logic              i_fifo_done;
    logic              i_done;
    // dcache side
    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_fifo_data;
    logic              d_fifo_wen;
    logic [IDX_W-1:0]  d_fifo_idx;
    logic              d_fifo_done;
    logic              d_done;
    // shared read data and axi_ctl side
    logic [DATA_W-1:0] rd_data;
    logic              m_req;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_fifo_data;
    logic              m_fifo_wen;
    logic              m_fifo_done;
    logic [IDX_W-1:0]  m_fifo_idx;
    logic              m_done;
    logic [DATA_W-1:0] m_data;

    modport slave (
        input  i_req, i_addr, i_fifo_idx, i_fifo_done,
        input  d_req, d_rw, d_addr, d_fifo_data, d_fifo_wen, d_fifo_idx, d_fifo_done,
        input  m_done, m_data,
        output i_done, d_done, rd_data,
        output m_req, m_rw, m_addr, m_fifo_data, m_fifo_wen, m_fifo_done, m_fifo_idx
    );

    modport master (
        output i_req, i_addr, i_fifo_idx, i_fifo_done,
        output d_req, d_rw, d_addr, d_fifo_data, d_fifo_wen, d_fifo_idx, d_fifo_done,
        output m_done, m_data,
        input  i_done, d_done, rd_data,
        input  m_req, m_rw, m_addr, m_fifo_data, m_fifo_wen, m_fifo_done, m_fifo_idx
    );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
//----------------------------------------------------------------------------
// Module  : mem_port_arbiter
// Brief   : Shares the axi_ctl port between icache and dcache with held grants,
//           round-robin ties, a turnaround gap and a starvation watchdog.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int IDX_W       = 9,
    parameter int TURN_CYCLES = 1,
    parameter int HOLD_MAX    = 256
) (
    input  wire logic        clk,
    input  wire logic        rst,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]       grant,
    output logic             err_starve
);

    localparam int HOLD_W = $clog2(HOLD_MAX + 1);
    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(HOLD_MAX);
    localparam logic [TURN_W-1:0] c_TURN_END = TURN_W'(TURN_CYCLES - 1);
    localparam logic              c_RR_I     = 1'b0;
    localparam logic              c_RR_D     = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_I = 2'd1,
        S_GNT_D = 2'd2,
        S_TURN  = 2'd3
    } state_t;

    state_t              r_state,      w_state_nxt;
    logic                r_rr_last,    w_rr_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt,   w_hold_nxt;
    logic [TURN_W-1:0]   r_turn_cnt,   w_turn_nxt;
    logic                r_err_starve, w_err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_last    <= c_RR_I;
            r_hold_cnt   <= '0;
            r_turn_cnt   <= '0;
            r_err_starve <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_last    <= w_rr_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_turn_cnt   <= w_turn_nxt;
            r_err_starve <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_last;
        w_hold_nxt  = r_hold_cnt;
        w_turn_nxt  = r_turn_cnt;
        w_err_nxt   = r_err_starve;

        case (r_state)
            S_IDLE: begin
                // On a tie the master that did not own the port last wins.
                if (bus.d_req && (!bus.i_req || r_rr_last == c_RR_I)) begin
                    w_state_nxt = S_GNT_D;
                    w_rr_nxt    = c_RR_D;
                    w_hold_nxt  = '0;
                end else if (bus.i_req) begin
                    w_state_nxt = S_GNT_I;
                    w_rr_nxt    = c_RR_I;
                    w_hold_nxt  = '0;
                end
            end
            S_GNT_I: begin
                if (!bus.i_req) begin
                    w_state_nxt = S_TURN;
                    w_turn_nxt  = '0;
                end else if (bus.d_req && r_hold_cnt != c_HOLD_MAX) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_GNT_D: begin
                if (!bus.d_req) begin
                    w_state_nxt = S_TURN;
                    w_turn_nxt  = '0;
                end else if (bus.i_req && r_hold_cnt != c_HOLD_MAX) begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end
            S_TURN: begin
                if (r_turn_cnt == c_TURN_END) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_turn_nxt = r_turn_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Watchdog only flags; the owning master keeps the port.
        if ((r_state == S_GNT_I || r_state == S_GNT_D) && w_hold_nxt == c_HOLD_MAX) begin
            w_err_nxt = 1'b1;
        end
    end

    always_comb begin
        bus.m_req       = 1'b0;
        bus.m_rw        = 1'b0;
        bus.m_addr      = '0;
        bus.m_fifo_data = '0;
        bus.m_fifo_wen  = 1'b0;
        bus.m_fifo_done = 1'b0;
        bus.m_fifo_idx  = '0;
        bus.i_done      = 1'b0;
        bus.d_done      = 1'b0;

        case (r_state)
            S_GNT_I: begin
                bus.m_req       = bus.i_req;
                bus.m_addr      = bus.i_addr;
                bus.m_fifo_idx  = bus.i_fifo_idx;
                bus.m_fifo_done = bus.i_fifo_done;
                bus.i_done      = bus.m_done;
            end
            S_GNT_D: begin
                bus.m_req       = bus.d_req;
                bus.m_rw        = bus.d_rw;
                bus.m_addr      = bus.d_addr;
                bus.m_fifo_data = bus.d_fifo_data;
                bus.m_fifo_wen  = bus.d_fifo_wen;
                bus.m_fifo_idx  = bus.d_fifo_idx;
                bus.m_fifo_done = bus.d_fifo_done;
                bus.d_done      = bus.m_done;
            end
            default: begin
            end
        endcase
    end

    assign bus.rd_data = bus.m_data;
    assign grant       = {r_state == S_GNT_D, r_state == S_GNT_I};
    assign err_starve  = r_err_starve;

endmodule

`default_nettype wire
